// File: rtl/vdp_super_vram_fetch.sv
// Slot-based VRAM fetch sequencer: display reads own a slot while drawing, CPU byte
// accesses fill the free slots, and a refresh strobe is issued once per line.
module vdp_super_vram_fetch #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_super,
  input  logic        super_res_drawing,
  input  logic [9:0]  cx,
  input  logic [16:0] super_res_vram_addr,
  output logic [31:0] vrm_32,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        mem_refresh,
  output logic        read_late
);

  typedef enum logic [1:0] {IDLE, DISP_RD, CPU_RD, CPU_WR} state_e;

  // The refresh register is loaded one cycle early so the strobe is visible while cx==723.
  localparam logic [9:0] REFRESH_PRE_CX = 10'd722;

  state_e      state_q;
  state_e      grant_d;
  logic        pend_q;
  logic [31:0] hold_q;
  logic [1:0]  lane_q;
  logic [31:0] vrm_32_q;
  logic        cpu_ack_q;
  logic [7:0]  cpu_rdata_q;
  logic        mem_req_q;
  logic        mem_wr_q;
  logic [16:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        mem_refresh_q;
  logic        read_late_q;

  logic [1:0]  phase;
  logic        in_win;
  logic        take;
  logic        late;
  logic [31:0] data_sel;

  assign phase = cx[1:0];
  // Data later than MEM_LAT cycles after the command counts as missing.
  assign in_win   = (phase == 2'd2) || ((phase == 2'd3) && (MEM_LAT > 1));
  assign take     = pend_q && mem_rdata_valid && in_win;
  assign late     = pend_q && !take;
  assign data_sel = take ? mem_rdata : hold_q;

  always_comb begin
    // NOTE: default first so every path assigns grant_d and no latch is inferred.
    grant_d = IDLE;
    if (vdp_super && super_res_drawing) begin
      grant_d = DISP_RD;
    end else if (cpu_req) begin
      grant_d = cpu_wr ? CPU_WR : CPU_RD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      hold_q        <= '0;
      lane_q        <= '0;
      vrm_32_q      <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      mem_refresh_q <= 1'b0;
      read_late_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      mem_req_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      mem_refresh_q <= (cx == REFRESH_PRE_CX);
      if (take) begin
        hold_q <= mem_rdata;
        pend_q <= 1'b0;
      end
      case (phase)
        2'd0: begin
          state_q <= grant_d;
          if (grant_d != IDLE) begin
            mem_req_q  <= 1'b1;
            mem_wr_q   <= (grant_d == CPU_WR);
            pend_q     <= (grant_d != CPU_WR);
            lane_q     <= cpu_addr[1:0];
            mem_addr_q <= (grant_d == DISP_RD) ? super_res_vram_addr : cpu_addr[18:2];
            if (grant_d == CPU_WR) begin
              mem_wdata_q <= {4{cpu_wdata}};
              mem_wmask_q <= 4'b0001 << cpu_addr[1:0];
            end else begin
              mem_wmask_q <= 4'b0000;
            end
          end
        end
        2'd1: begin
          if (state_q == CPU_WR) cpu_ack_q <= 1'b1;
        end
        2'd3: begin
          if (late) read_late_q <= 1'b1;
          if (!vdp_super) begin
            vrm_32_q <= '0;
          end else if (state_q == DISP_RD && !late) begin
            vrm_32_q <= data_sel;
          end
          if (state_q == CPU_RD) begin
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= late ? 8'h00 : data_sel[{lane_q, 3'b000} +: 8];
          end
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign vrm_32      = vrm_32_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_refresh = mem_refresh_q;
  assign read_late   = read_late_q;

endmodule

// File: tb/tb_vdp_super_vram_fetch.sv
// Bench for vdp_super_vram_fetch: a slot-level reference (grant priority, byte-lane
// arithmetic, word-addressed memory array) drives directed and random slots.
module tb_vdp_super_vram_fetch;

  logic        clk;
  logic        reset_n;
  logic        vdp_super;
  logic        super_res_drawing;
  logic [9:0]  cx;
  logic [16:0] super_res_vram_addr;
  logic [31:0] vrm_32;
  logic        cpu_req;
  logic        cpu_wr;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_refresh;
  logic        read_late;

  vdp_super_vram_fetch #(.MEM_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .vdp_super(vdp_super),
    .super_res_drawing(super_res_drawing), .cx(cx),
    .super_res_vram_addr(super_res_vram_addr), .vrm_32(vrm_32),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_refresh(mem_refresh), .read_late(read_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic ref_en = 1'b0;

  logic [31:0] mem [int];
  logic [31:0] exp_vrm;
  logic        exp_late;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    if (mem.exists(a)) return mem[a];
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5BD1_E995;
  endfunction

  // One clock; outputs are looked at 1 time unit after the edge, when cx moves on.
  task automatic tick();
    @(posedge clk);
    #1;
    cx = (cx == 10'd799) ? 10'd0 : cx + 10'd1;
    if (ref_en && reset_n) check("refresh", {31'd0, mem_refresh}, {31'd0, cx == 10'd723});
  endtask

  // Runs one whole slot from its phase-0 cycle; lat 0 withholds read data.
  task automatic run_slot(input logic sup, input logic draw, input logic req, input logic wr,
                          input logic [18:0] caddr, input logic [7:0] wdata,
                          input logic [16:0] daddr, input int lat, input logic drop_req);
    logic        g_disp, g_cpu, is_rd, lost;
    int          exp_addr;
    logic [1:0]  lane;
    logic [31:0] resp, expd, tmp, w;
    vdp_super = sup; super_res_drawing = draw; cpu_req = req; cpu_wr = wr;
    cpu_addr = caddr; cpu_wdata = wdata; super_res_vram_addr = daddr;
    g_disp   = sup && draw;
    g_cpu    = !g_disp && req;
    is_rd    = g_disp || (g_cpu && !wr);
    exp_addr = g_disp ? int'(daddr) : int'(caddr) / 4;
    lane     = caddr[1:0];

    tick();  // phase 1
    check("mem_req_p1", {31'd0, mem_req}, {31'd0, g_disp || g_cpu});
    if (g_disp || g_cpu) begin
      check("mem_addr", {15'd0, mem_addr}, 32'(exp_addr));
      check("mem_wr", {31'd0, mem_wr}, {31'd0, g_cpu && wr});
    end
    if (g_cpu && wr) begin
      check("mem_wdata", mem_wdata, {wdata, wdata, wdata, wdata});
      check("mem_wmask", {28'd0, mem_wmask}, 32'(1) << lane);
      w = word_at(exp_addr);
      w[8*lane +: 8] = wdata;
      mem[exp_addr] = w;
    end
    resp = word_at(int'(mem_addr));
    expd = word_at(exp_addr);
    if (drop_req) cpu_req = 1'b0;

    tick();  // phase 2
    mem_rdata_valid = (lat == 1);
    mem_rdata = (lat == 1 && is_rd) ? resp : $urandom;
    check("ack_p2", {31'd0, cpu_ack}, {31'd0, g_cpu && wr});
    check("mem_req_p2", {31'd0, mem_req}, 32'd0);

    tick();  // phase 3
    mem_rdata_valid = is_rd && (lat == 2);
    mem_rdata = (lat == 2) ? resp : $urandom;
    check("ack_p3", {31'd0, cpu_ack}, 32'd0);
    check("mem_req_p3", {31'd0, mem_req}, 32'd0);
    check("vrm_held", vrm_32, exp_vrm);

    tick();  // phase 0 of the next slot
    mem_rdata_valid = 1'b0;
    mem_rdata = $urandom;
    lost = is_rd && (lat == 0);
    if (lost) exp_late = 1'b1;
    if (!sup) exp_vrm = 32'd0;
    else if (g_disp && !lost) exp_vrm = expd;
    check("vrm_32", vrm_32, exp_vrm);
    check("read_late", {31'd0, read_late}, {31'd0, exp_late});
    check("ack_rd", {31'd0, cpu_ack}, {31'd0, g_cpu && !wr});
    if (g_cpu && !wr) begin
      tmp = lost ? 32'd0 : (expd >> (8 * lane));
      check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, tmp[7:0]});
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cx = 10'd0; vdp_super = 1'b0; super_res_drawing = 1'b0;
    super_res_vram_addr = '0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; mem_rdata = '0; mem_rdata_valid = 1'b0;
    exp_vrm = 32'd0; exp_late = 1'b0;
    mem[32'h10] = 32'hA1B2_C3D4;
    mem[32'h11] = 32'h1122_3344;
    repeat (5) tick();
    check("rst_vrm", vrm_32, 32'd0);
    check("rst_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_addr", {15'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rst_refresh", {31'd0, mem_refresh}, 32'd0);
    check("rst_late", {31'd0, read_late}, 32'd0);
    reset_n = 1'b1;
    while (cx[1:0] != 2'd0) tick();
    ref_en = 1'b1;

    // Display read, then an idle slot showing it held.
    run_slot(1, 1, 0, 0, 19'h0, 8'h00, 17'h00010, 2, 0);
    run_slot(1, 0, 0, 0, 19'h0, 8'h00, 17'h00010, 2, 0);
    // CPU write to byte 2 of dword 0x11.
    run_slot(1, 0, 1, 1, 19'h00046, 8'h5A, 17'h00010, 1, 0);
    // CPU read held off by three display slots, then served (lane 3 of 0x115A3344).
    for (int i = 0; i < 3; i++) run_slot(1, 1, 1, 0, 19'h00047, 8'h00, 17'h00010, 2, 0);
    run_slot(1, 0, 1, 0, 19'h00047, 8'h00, 17'h00010, 2, 0);
    // Request dropped right after the grant still completes.
    run_slot(1, 0, 1, 0, 19'h00044, 8'h00, 17'h00010, 1, 1);

    // Walk to the slot holding cx==723 with a display read in flight.
    while (cx != 10'd720) run_slot(1, 0, 0, 0, 19'h0, 8'h00, 17'h0, 1, 0);
    run_slot(1, 1, 0, 0, 19'h0, 8'h00, 17'h00011, 2, 0);

    // Reset during phase 2 of a CPU read; the late data must be ignored.
    vdp_super = 1'b1; super_res_drawing = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00047;
    tick();
    check("rstmid_req", {31'd0, mem_req}, 32'd1);
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rstmid_vrm", vrm_32, 32'd0);
    check("rstmid_ack", {31'd0, cpu_ack}, 32'd0);
    check("rstmid_req0", {31'd0, mem_req}, 32'd0);
    check("rstmid_addr", {15'd0, mem_addr}, 32'd0);
    check("rstmid_wdata", mem_wdata, 32'd0);
    check("rstmid_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rstmid_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    reset_n = 1'b1;
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rdata_valid = 1'b0;
    exp_vrm = 32'd0; exp_late = 1'b0;
    check("rstmid_noack", {31'd0, cpu_ack}, 32'd0);
    check("rstmid_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rstmid_late", {31'd0, read_late}, 32'd0);
    check("rstmid_vrm2", vrm_32, 32'd0);

    // Error paths: good read, withheld read, late CPU read, then super mode off.
    run_slot(1, 1, 0, 0, 19'h0, 8'h00, 17'h00010, 2, 0);
    run_slot(1, 1, 0, 0, 19'h0, 8'h00, 17'h00012, 0, 0);
    run_slot(1, 0, 1, 0, 19'h00045, 8'h00, 17'h0, 0, 0);
    run_slot(0, 1, 0, 0, 19'h0, 8'h00, 17'h00010, 2, 0);
    run_slot(0, 1, 1, 1, 19'h00049, 8'hC3, 17'h00010, 1, 0);
    run_slot(0, 1, 1, 0, 19'h00049, 8'h00, 17'h00010, 2, 0);

    // Random slots against the reference.
    for (int i = 0; i < 320; i++) begin
      run_slot(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               19'($urandom_range(0, 63)), 8'($urandom), 17'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2)),
               1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
